divider_32: RTL and testbench

Sequential 32-bit restoring divider for the processor's arithmetic unit, the inverse counterpart of `multiplier_32`. It accepts a dividend and divisor, iterates one quotient bit per enabled clock, and raises `dne` when quotient and remainder are valid. It shares the multiplier's `ena`/`dne` handshake so the execute stage can drive both units identically.

---
 rtl/divider_32.sv | 142 ++++++++++++++
 tb/tb_divider_32.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_32.sv
// Sequential 32-bit restoring divider, one quotient bit per enabled clock, ena/dne handshake.
// Define DIVIDER_32_SIGNED_EN for two's-complement operands (adds a sign-fixup FIX state).
module divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              ld,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  r,
    output logic              dne,
    output logic              dbz
);

`ifdef DIVIDER_32_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [4:0]       cnt;
    logic [WIDTH:0]   partial;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_step;

`ifdef DIVIDER_32_SIGNED_EN
    logic negq;
    logic negr;

    assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // The dividend register doubles as the quotient: its MSB leaves as the LSB takes the new bit.
    always_comb begin
        partial = {rem, dvd[WIDTH-1]};
        ge      = (partial >= {1'b0, dvs});
        rem_nxt = ge ? (partial[WIDTH-1:0] - dvs) : partial[WIDTH-1:0];
        quo_nxt = {dvd[WIDTH-2:0], ge};
    end

    assign last_step = (cnt == 5'd31);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ena) begin
            if (ld) begin
                state_nxt = (b == '0) ? DONE : RUN;
            end else begin
                case (state)
                    IDLE: state_nxt = IDLE;
`ifdef DIVIDER_32_SIGNED_EN
                    RUN:  state_nxt = last_step ? FIX : RUN;
                    FIX:  state_nxt = DONE;
`else
                    RUN:  state_nxt = last_step ? DONE : RUN;
`endif
                    DONE: state_nxt = DONE;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            dne <= 1'b0;
            dbz <= 1'b0;
`ifdef DIVIDER_32_SIGNED_EN
            negq <= 1'b0;
            negr <= 1'b0;
`endif
        end else if (ena) begin
            if (ld) begin
                dvd <= a_mag;
                dvs <= b_mag;
                rem <= '0;
                cnt <= '0;
                dne <= 1'b0;
                dbz <= 1'b0;
`ifdef DIVIDER_32_SIGNED_EN
                negq <= a[WIDTH-1] ^ b[WIDTH-1];
                negr <= a[WIDTH-1];
`endif
                if (b == '0) begin
                    q   <= '1;
                    r   <= a;
                    dne <= 1'b1;
                    dbz <= 1'b1;
                end
            end else if (state == RUN) begin
                dvd <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt + 5'd1;
`ifndef DIVIDER_32_SIGNED_EN
                if (last_step) begin
                    q   <= quo_nxt;
                    r   <= rem_nxt;
                    dne <= 1'b1;
                end
`endif
            end
`ifdef DIVIDER_32_SIGNED_EN
            else if (state == FIX) begin
                q   <= negq ? (~dvd + 1'b1) : dvd;
                r   <= negr ? (~rem + 1'b1) : rem;
                dne <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_divider_32.sv
// Randomized self-checking bench for divider_32 against a plain-arithmetic reference model.
// Honours DIVIDER_32_SIGNED_EN so the same bench covers both builds.
module tb_divider_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        ld;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dne;
    logic        dbz;

    int checks   = 0;
    int failures = 0;

`ifdef DIVIDER_32_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    divider_32 dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .ld  (ld),
        .a   (a),
        .b   (b),
        .q   (q),
        .r   (r),
        .dne (dne),
        .dbz (dbz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: quotient truncates toward zero, remainder follows the dividend; x/0 gives all ones and x.
    function automatic void refModel(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] eq, output logic [31:0] er);
        if (y == 32'd0) begin
            eq = 32'hFFFFFFFF;
            er = x;
        end else begin
`ifdef DIVIDER_32_SIGNED_EN
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                eq = 32'h80000000;
                er = 32'd0;
            end else begin
                eq = $signed(x) / $signed(y);
                er = $signed(x) % $signed(y);
            end
`else
            eq = x / y;
            er = x % y;
`endif
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a   = x;
        b   = y;
        ld  = 1'b1;
        ena = 1'b1;
        @(negedge clk);
        ld  = 1'b0;
    endtask

    // Counts enabled edges after the load edge until dne; optional random ena stalls.
    task automatic waitDone(input string tag, input logic stall, output int edges);
        int guard;
        edges = 0;
        guard = 0;
        while (!dne && guard < 1000) begin
            ena = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (ena) edges++;
            guard++;
        end
        ena = 1'b1;
        if (!dne) checkOutput({tag, "_timeout"}, {31'd0, dne}, 32'd1);
    endtask

    task automatic runCase(input string tag, input logic [31:0] x, input logic [31:0] y, input logic stall);
        logic [31:0] eq, er, prevq;
        int          edges;
        prevq = q;
        applyStimulus(x, y);
        if (y != 32'd0) checkOutput({tag, "_qhold"}, q, prevq);
        waitDone(tag, stall, edges);
        refModel(x, y, eq, er);
        checkOutput({tag, "_q"}, q, eq);
        checkOutput({tag, "_r"}, r, er);
        checkOutput({tag, "_dbz"}, {31'd0, dbz}, {31'd0, (y == 32'd0)});
        checkOutput({tag, "_lat"}, edges, (y == 32'd0) ? 32'd0 : LAT);
    endtask

    initial begin
        int          edges;
        logic [31:0] x, y;
        rst = 1'b0;
        ena = 1'b0;
        ld  = 1'b0;
        a   = '0;
        b   = '0;
        #2;
        checkOutput("reset_q", q, 32'd0);
        checkOutput("reset_r", r, 32'd0);
        checkOutput("reset_dne", {31'd0, dne}, 32'd0);
        checkOutput("reset_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_dne", {31'd0, dne}, 32'd0);

        runCase("d30_6", 32'd30, 32'd6, 1'b0);
        checkOutput("d30_6_const", q, 32'd5);
        runCase("dmax_big", 32'hFFFFFFFF, 32'h80000001, 1'b0);
        runCase("dmax_16", 32'hFFFFFFFF, 32'd16, 1'b0);
        runCase("dbz", 32'd1234, 32'd0, 1'b0);
        checkOutput("dbz_const_r", r, 32'd1234);
`ifdef DIVIDER_32_SIGNED_EN
        runCase("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b0);
        checkOutput("s_m7_2_const", q, 32'hFFFFFFFD);
        runCase("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b0);
        checkOutput("s_7_m2_const", r, 32'd1);
        runCase("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 255);
                2:       y = $urandom | 32'h80000000;
                default: y = $urandom;
            endcase
            runCase("rand", x, y, 1'b1);
        end

        // Stall at step 10, then abort and restart at step 20.
        applyStimulus(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stall_dne", {31'd0, dne}, 32'd0);
        ena = 1'b1;
        repeat (9) @(negedge clk);
        applyStimulus(32'd100, 32'd9);
        checkOutput("abort_dne", {31'd0, dne}, 32'd0);
        waitDone("abort", 1'b0, edges);
        checkOutput("abort_q", q, 32'd11);
        checkOutput("abort_r", r, 32'd1);
        checkOutput("abort_lat", edges, LAT);

        // Load arrives on the very edge that would have finished the previous division.
        applyStimulus(32'd50, 32'd3);
        repeat (LAT - 1) @(negedge clk);
        a  = 32'd200;
        b  = 32'd7;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        checkOutput("race_dne", {31'd0, dne}, 32'd0);
        waitDone("race", 1'b0, edges);
        checkOutput("race_q", q, 32'd28);
        checkOutput("race_r", r, 32'd4);
        checkOutput("race_lat", edges, LAT);

        // Asynchronous reset between edges mid-division.
        applyStimulus(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("areset_q", q, 32'd0);
        checkOutput("areset_r", r, 32'd0);
        checkOutput("areset_dne", {31'd0, dne}, 32'd0);
        checkOutput("areset_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("post_reset_dne", {31'd0, dne}, 32'd0);
        checkOutput("post_reset_q", q, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
